// File: rtl/rng_stream_checker.sv
// Synchronises to an 8-bit LFSR byte stream and counts mismatches once locked.
// Also runs a per-window monobit (ones count) bias test over every valid byte.
module rng_stream_checker #(
   parameter int LOCK_COUNT  = 4,
   parameter int LOSS_COUNT  = 3,
   parameter int WINDOW_LOG2 = 8,
   parameter int BIAS_TOL    = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       clear,
   output logic       locked,
   output logic       err_pulse,
   output logic [7:0] err_cnt,
   output logic       window_done,
   output logic       bias_flag
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);
   localparam int AW = WINDOW_LOG2 + 4;

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t          state_reg, state_next;
   logic [7:0]      expected_reg, expected_next;
   logic [MW-1:0]   match_reg, match_next;
   logic [LW-1:0]   miss_reg, miss_next;
   logic            err_hit;

   logic [AW-1:0]          acc_reg;
   logic [WINDOW_LOG2-1:0] bcnt_reg;
   logic [3:0]             ones;
   logic [AW-1:0]          total;
   logic [AW-1:0]          half;
   logic [AW-1:0]          dev_abs;
   logic                   bias_hit;
   logic                   window_end;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= SEARCH;
         expected_reg <= 8'h00;
         match_reg    <= '0;
         miss_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         expected_reg <= expected_next;
         match_reg    <= match_next;
         miss_reg     <= miss_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      expected_next = expected_reg;
      match_next    = match_reg;
      miss_next     = miss_reg;
      err_hit       = 1'b0;
      if (in_valid) begin
         case (state_reg)
            SEARCH: begin
               if (in_data != 8'h00) begin
                  expected_next = lfsr_next(in_data);
                  match_next    = '0;
                  state_next    = VERIFY;
               end
            end
            VERIFY: begin
               if (in_data == expected_reg) begin
                  expected_next = lfsr_next(in_data);
                  match_next    = match_reg + 1'b1;
                  if (match_reg + 1'b1 == MW'(LOCK_COUNT)) begin
                     state_next = LOCKED;
                     miss_next  = '0;
                  end
               end else if (in_data != 8'h00) begin
                  expected_next = lfsr_next(in_data);
                  match_next    = '0;
               end else begin
                  state_next = SEARCH;
               end
            end
            LOCKED: begin
               // Flywheel: keep stepping our own prediction, never reload from data.
               expected_next = lfsr_next(expected_reg);
               if (in_data == expected_reg) begin
                  miss_next = '0;
               end else begin
                  err_hit   = 1'b1;
                  miss_next = miss_reg + 1'b1;
                  if (miss_reg + 1'b1 == LW'(LOSS_COUNT))
                     state_next = SEARCH;
               end
            end
            default: state_next = SEARCH;
         endcase
      end
   end

   assign locked = (state_reg == LOCKED);

   always_comb begin
      ones = 4'd0;
      for (int i = 0; i < 8; i++)
         ones = ones + {3'd0, in_data[i]};
   end

   assign total      = acc_reg + AW'(ones);
   assign half       = AW'(1) << (WINDOW_LOG2 + 2);
   assign dev_abs    = (total >= half) ? (total - half) : (half - total);
   assign bias_hit   = dev_abs > AW'(BIAS_TOL);
   assign window_end = in_valid && !clear && (&bcnt_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse   <= 1'b0;
         err_cnt     <= 8'd0;
         window_done <= 1'b0;
         bias_flag   <= 1'b0;
         acc_reg     <= '0;
         bcnt_reg    <= '0;
      end else begin
         err_pulse   <= err_hit;
         window_done <= window_end;
         // Clear outranks the byte for counters only; err_pulse above still fires.
         if (clear) begin
            err_cnt  <= 8'd0;
            acc_reg  <= '0;
            bcnt_reg <= '0;
         end else begin
            if (err_hit && err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
            if (in_valid) begin
               if (window_end) begin
                  acc_reg   <= '0;
                  bcnt_reg  <= '0;
                  bias_flag <= bias_hit;
               end else begin
                  acc_reg  <= total;
                  bcnt_reg <= bcnt_reg + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rng_stream_checker.sv
// Scoreboard bench for rng_stream_checker: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_rng_stream_checker;

   localparam int LOCK = 4;
   localparam int LOSS = 3;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       clear;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_cnt;
   logic       window_done;
   logic       bias_flag;

   rng_stream_checker dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .clear       (clear),
      .locked      (locked),
      .err_pulse   (err_pulse),
      .err_cnt     (err_cnt),
      .window_done (window_done),
      .bias_flag   (bias_flag)
   );

   typedef struct packed {
      logic       locked;
      logic       err_pulse;
      logic [7:0] err_cnt;
      logic       window_done;
      logic       bias_flag;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   int         m_state;
   logic [7:0] m_exp;
   int         m_match, m_miss, m_err, m_acc, m_bc;
   logic       m_bias;
   logic [7:0] gen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] tb_next(input logic [7:0] s);
      return (s << 1) | {7'd0, ^(s & 8'hB8)};
   endfunction

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic model_reset();
      m_state = 0; m_exp = 8'h00; m_match = 0; m_miss = 0;
      m_err = 0; m_acc = 0; m_bc = 0; m_bias = 1'b0;
   endtask

   task automatic send(input logic v, input logic [7:0] d, input logic clr);
      exp_t e;
      exp_t got;
      @(negedge clk);
      in_valid = v; in_data = d; clear = clr;
      e = '0;
      if (v) begin
         case (m_state)
            0: if (d != 8'h00) begin m_exp = tb_next(d); m_match = 0; m_state = 1; end
            1: begin
               if (d == m_exp) begin
                  m_match++; m_exp = tb_next(d);
                  if (m_match == LOCK) begin m_state = 2; m_miss = 0; end
               end else if (d != 8'h00) begin
                  m_exp = tb_next(d); m_match = 0;
               end else m_state = 0;
            end
            default: begin
               if (d == m_exp) m_miss = 0;
               else begin
                  e.err_pulse = 1'b1;
                  if (m_err < 255) m_err++;
                  m_miss++;
                  if (m_miss == LOSS) m_state = 0;
               end
               m_exp = tb_next(m_exp);
            end
         endcase
      end
      if (clr) begin
         m_err = 0; m_acc = 0; m_bc = 0;
      end else if (v) begin
         m_acc += $countones(d);
         m_bc++;
         if (m_bc == 256) begin
            e.window_done = 1'b1;
            m_bias = (m_acc > 1024 + 64) || (m_acc < 1024 - 64);
            m_acc = 0; m_bc = 0;
         end
      end
      e.locked    = (m_state == 2);
      e.err_cnt   = 8'(m_err);
      e.bias_flag = m_bias;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check_eq("locked",      8'(locked),      8'(got.locked));
      check_eq("err_pulse",   8'(err_pulse),   8'(got.err_pulse));
      check_eq("err_cnt",     err_cnt,         got.err_cnt);
      check_eq("window_done", 8'(window_done), 8'(got.window_done));
      check_eq("bias_flag",   8'(bias_flag),   8'(got.bias_flag));
      $display("txn v=%b d=%02h clr=%b -> locked=%b ep=%b ec=%0d wd=%b bf=%b",
               v, d, clr, locked, err_pulse, err_cnt, window_done, bias_flag);
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_locked"}, 8'(locked),      8'd0);
      check_eq({tag, "_ep"},     8'(err_pulse),   8'd0);
      check_eq({tag, "_ec"},     err_cnt,         8'd0);
      check_eq({tag, "_wd"},     8'(window_done), 8'd0);
      check_eq({tag, "_bf"},     8'(bias_flag),   8'd0);
   endtask

   task automatic lock_from(input logic [7:0] seed);
      gen = seed;
      send(1'b1, gen, 1'b0);
      for (int i = 0; i < 4; i++) begin
         gen = tb_next(gen);
         send(1'b1, gen, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Canonical lock sequence 01,02,04,08,11
      lock_from(8'h01);
      check_eq("lock_after_11", 8'(locked), 8'd1);
      check_eq("lock_errcnt",   err_cnt,    8'd0);

      // One corrupted byte, then the correct stream continues
      gen = tb_next(gen);
      send(1'b1, gen ^ 8'h40, 1'b0);
      check_eq("single_err_pulse", 8'(err_pulse), 8'd1);
      for (int i = 0; i < 3; i++) begin
         gen = tb_next(gen);
         send(1'b1, gen, 1'b0);
      end
      check_eq("single_err_cnt",  err_cnt,    8'd1);
      check_eq("single_err_lock", 8'(locked), 8'd1);

      // Three consecutive misses drop lock (err_cnt keeps the earlier miss too)
      for (int i = 0; i < 3; i++) begin
         gen = tb_next(gen);
         send(1'b1, gen ^ 8'h01, 1'b0);
         if (i < 2) check_eq("loss_still_locked", 8'(locked), 8'd1);
      end
      check_eq("loss_unlocked", 8'(locked), 8'd0);
      check_eq("loss_errcnt",   err_cnt,    8'd4);
      for (int i = 0; i < 3; i++) send(1'b1, 8'h00, 1'b0);
      check_eq("zeros_search", 8'(locked), 8'd0);

      // Monobit: all-ones window, then a balanced window
      send(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 256; i++) begin
         send(1'b1, 8'hFF, 1'b0);
         if (i == 254) check_eq("wd_not_early", 8'(window_done), 8'd0);
      end
      check_eq("ff_window_done", 8'(window_done), 8'd1);
      check_eq("ff_bias",        8'(bias_flag),   8'd1);
      send(1'b0, 8'h00, 1'b0);
      check_eq("bias_held", 8'(bias_flag), 8'd1);
      for (int i = 0; i < 256; i++) send(1'b1, (i % 2 == 0) ? 8'h0F : 8'hF0, 1'b0);
      check_eq("alt_window_done", 8'(window_done), 8'd1);
      check_eq("alt_bias",        8'(bias_flag),   8'd0);

      // Saturation: alternate miss/match so lock is held while errors pile up
      lock_from(8'h5A);
      check_eq("relock_5a", 8'(locked), 8'd1);
      for (int i = 0; i < 260; i++) begin
         gen = tb_next(gen);
         send(1'b1, gen ^ 8'h80, 1'b0);
         gen = tb_next(gen);
         send(1'b1, gen, 1'b0);
      end
      check_eq("sat_errcnt", err_cnt,    8'd255);
      check_eq("sat_locked", 8'(locked), 8'd1);
      gen = tb_next(gen);
      send(1'b1, gen ^ 8'h01, 1'b1);
      check_eq("clr_errcnt", err_cnt,       8'd0);
      check_eq("clr_pulse",  8'(err_pulse), 8'd1);
      gen = tb_next(gen);
      send(1'b1, gen, 1'b0);
      gen = tb_next(gen);
      send(1'b1, gen ^ 8'h02, 1'b0);
      gen = tb_next(gen);
      send(1'b1, gen, 1'b0);
      check_eq("pre_rst_errcnt", err_cnt, 8'd1);

      // Asynchronous reset mid-cycle while locked and mid-window
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      gen = 8'h33;
      send(1'b1, gen, 1'b0);
      for (int i = 0; i < 4; i++) begin
         gen = tb_next(gen);
         send(1'b1, gen, 1'b0);
         if (i < 3) check_eq("relock_wait", 8'(locked), 8'd0);
      end
      check_eq("relock_after_5", 8'(locked), 8'd1);
      send(1'b0, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
